alu: RTL and testbench

// - Registered BITS-wide integer ALU: add/sub with carry-in, bitwise AND/XOR.
// - Flags: carry/borrow (o_carry) and signed overflow (o_ERR).
// - Operands are sampled each i_clk edge; results appear one cycle later.
// - Used as the arithmetic slice of the datapath and checked against its synthesized netlist.

---
 rtl/alu.sv | 79 +++++++
 tb/tb_alu.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered BITS-wide ALU: ADD/SUB with carry/borrow-in, AND, XOR, carry and signed-overflow flags.
// Optional feature: define ALU_SATURATE_EN to clamp overflowing ADD/SUB results to the signed limit.
module alu #(
  parameter int BITS = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  input  logic            i_carry,
  input  logic [1:0]      i_op,
  output logic [BITS-1:0] o_out,
  output logic            o_carry,
  output logic            o_ERR
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

`ifdef ALU_SATURATE_EN
  localparam logic [BITS-1:0] POS_LIMIT = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] NEG_LIMIT = {1'b1, {(BITS-1){1'b0}}};
`endif

  logic [BITS:0]   cin_ext;
  logic [BITS:0]   sum_ext;
  logic [BITS:0]   diff_ext;
  logic [BITS-1:0] result_next;
  logic            carry_next;
  logic            ovf_next;

  // One extra bit on add/sub: its MSB is the carry-out, or the borrow when the difference goes negative.
  always_comb begin
    cin_ext     = {{BITS{1'b0}}, i_carry};
    sum_ext     = {1'b0, i_a} + {1'b0, i_b} + cin_ext;
    diff_ext    = {1'b0, i_a} - {1'b0, i_b} - cin_ext;
    result_next = '0;
    carry_next  = 1'b0;
    ovf_next    = 1'b0;
    case (op_e'(i_op))
      OP_ADD: begin
        result_next = sum_ext[BITS-1:0];
        carry_next  = sum_ext[BITS];
        ovf_next    = (i_a[BITS-1] == i_b[BITS-1]) && (sum_ext[BITS-1] != i_a[BITS-1]);
      end
      OP_SUB: begin
        result_next = diff_ext[BITS-1:0];
        carry_next  = diff_ext[BITS];
        ovf_next    = (i_a[BITS-1] != i_b[BITS-1]) && (diff_ext[BITS-1] != i_a[BITS-1]);
      end
      OP_AND: result_next = i_a & i_b;
      OP_XOR: result_next = i_a ^ i_b;
      default: ;
    endcase
`ifdef ALU_SATURATE_EN
    // Overflow direction follows the sign of A for both ADD and SUB.
    if (ovf_next) begin
      result_next = i_a[BITS-1] ? NEG_LIMIT : POS_LIMIT;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_out   <= '0;
      o_carry <= 1'b0;
      o_ERR   <= 1'b0;
    end else begin
      o_out   <= result_next;
      o_carry <= carry_next;
      o_ERR   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu at BITS=8; expectations follow ALU_SATURATE_EN if defined.
module tb_alu;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] XOR = 2'b11;

`ifdef ALU_SATURATE_EN
  localparam logic [7:0] ADD_OVF_POS = 8'h7F;
  localparam logic [7:0] ADD_OVF_NEG = 8'h80;
  localparam logic [7:0] SUB_OVF_NEG = 8'h80;
  localparam logic [7:0] SUB_OVF_POS = 8'h7F;
`else
  localparam logic [7:0] ADD_OVF_POS = 8'h80;
  localparam logic [7:0] ADD_OVF_NEG = 8'h00;
  localparam logic [7:0] SUB_OVF_NEG = 8'h7F;
  localparam logic [7:0] SUB_OVF_POS = 8'h80;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [1:0] op;
    logic [7:0] out;
    logic       c;
    logic       e;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       carry_in;
  logic [1:0] op;
  logic [7:0] out;
  logic       carry_out;
  logic       err;

  int tests_run;
  int tests_failed;

  alu #(.BITS(8)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_a    (a),
    .i_b    (b),
    .i_carry(carry_in),
    .i_op   (op),
    .o_out  (out),
    .o_carry(carry_out),
    .o_ERR  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic apply_op(input logic r, input vec_t v);
    @(negedge clk);
    rst      = r;
    a        = v.a;
    b        = v.b;
    carry_in = v.cin;
    op       = v.op;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vectors(input string name, input vec_t v[]);
    for (int i = 0; i < v.size(); i++) begin
      apply_op(1'b0, v[i]);
      tests_run++;
      if ({out, carry_out, err} !== {v[i].out, v[i].c, v[i].e}) begin
        tests_failed++;
        $display("[TB] FAIL %s[%0d] a=%h b=%h cin=%b op=%b: got out=%h c=%b e=%b, want out=%h c=%b e=%b",
                 name, i, v[i].a, v[i].b, v[i].cin, v[i].op, out, carry_out, err,
                 v[i].out, v[i].c, v[i].e);
      end
    end
  endtask

  task automatic test_reset();
    apply_op(1'b1, '{a: 8'hFF, b: 8'h01, cin: 1'b1, op: ADD, out: 8'h00, c: 1'b0, e: 1'b0});
    tests_run++;
    if ({out, carry_out, err} !== {8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_initial: got out=%h c=%b e=%b, want 00 0 0", out, carry_out, err);
    end
    apply_op(1'b0, '{a: 8'h7F, b: 8'h80, cin: 1'b1, op: ADD, out: 8'h00, c: 1'b0, e: 1'b0});
    tests_run++;
    if ({out, carry_out, err} !== {8'h00, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got out=%h c=%b e=%b, want 00 1 0", out, carry_out, err);
    end
    apply_op(1'b1, '{a: 8'h7F, b: 8'h01, cin: 1'b0, op: ADD, out: 8'h00, c: 1'b0, e: 1'b0});
    tests_run++;
    if ({out, carry_out, err} !== {8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_clears: got out=%h c=%b e=%b, want 00 0 0", out, carry_out, err);
    end
  endtask

  task automatic test_add();
    vec_t v[];
    v = new[6];
    v[0] = '{a: 8'd10,  b: 8'd5,   cin: 1'b0, op: ADD, out: 8'd15,       c: 1'b0, e: 1'b0};
    v[1] = '{a: 8'h01,  b: 8'h82,  cin: 1'b0, op: ADD, out: 8'h83,       c: 1'b0, e: 1'b0};
    v[2] = '{a: 8'hFF,  b: 8'h01,  cin: 1'b0, op: ADD, out: 8'h00,       c: 1'b1, e: 1'b0};
    v[3] = '{a: 8'h7F,  b: 8'h01,  cin: 1'b0, op: ADD, out: ADD_OVF_POS, c: 1'b0, e: 1'b1};
    v[4] = '{a: 8'd15,  b: 8'd8,   cin: 1'b1, op: ADD, out: 8'd24,       c: 1'b0, e: 1'b0};
    v[5] = '{a: 8'h80,  b: 8'h80,  cin: 1'b0, op: ADD, out: ADD_OVF_NEG, c: 1'b1, e: 1'b1};
    run_vectors("add", v);
  endtask

  task automatic test_sub();
    vec_t v[];
    v = new[6];
    v[0] = '{a: 8'd8,   b: 8'd10,  cin: 1'b0, op: SUB, out: 8'hFE,       c: 1'b1, e: 1'b0};
    v[1] = '{a: 8'd15,  b: 8'd8,   cin: 1'b0, op: SUB, out: 8'd7,        c: 1'b0, e: 1'b0};
    v[2] = '{a: 8'h80,  b: 8'h01,  cin: 1'b0, op: SUB, out: SUB_OVF_NEG, c: 1'b0, e: 1'b1};
    v[3] = '{a: 8'd10,  b: 8'd9,   cin: 1'b1, op: SUB, out: 8'd0,        c: 1'b0, e: 1'b0};
    v[4] = '{a: 8'd5,   b: 8'd5,   cin: 1'b1, op: SUB, out: 8'hFF,       c: 1'b1, e: 1'b0};
    v[5] = '{a: 8'h7F,  b: 8'hFF,  cin: 1'b0, op: SUB, out: SUB_OVF_POS, c: 1'b1, e: 1'b1};
    run_vectors("sub", v);
  endtask

  task automatic test_logic();
    vec_t v[];
    v = new[4];
    v[0] = '{a: 8'd15,  b: 8'd8,   cin: 1'b0, op: AND, out: 8'd8,  c: 1'b0, e: 1'b0};
    v[1] = '{a: 8'h01,  b: 8'h82,  cin: 1'b0, op: XOR, out: 8'h83, c: 1'b0, e: 1'b0};
    v[2] = '{a: 8'hFF,  b: 8'hFF,  cin: 1'b1, op: AND, out: 8'hFF, c: 1'b0, e: 1'b0};
    v[3] = '{a: 8'h7F,  b: 8'hFF,  cin: 1'b1, op: XOR, out: 8'h80, c: 1'b0, e: 1'b0};
    run_vectors("logic", v);
  endtask

  // Outputs must hold the previous result until the edge, then show the new one; reset wins mid-stream.
  task automatic test_back_to_back();
    vec_t v[5];
    logic [9:0] prev;
    v[0] = '{a: 8'h10, b: 8'h20, cin: 1'b0, op: ADD, out: 8'h30, c: 1'b0, e: 1'b0};
    v[1] = '{a: 8'h10, b: 8'h20, cin: 1'b0, op: SUB, out: 8'hF0, c: 1'b1, e: 1'b0};
    v[2] = '{a: 8'hF0, b: 8'h3C, cin: 1'b1, op: AND, out: 8'h30, c: 1'b0, e: 1'b0};
    v[3] = '{a: 8'hF0, b: 8'h3C, cin: 1'b0, op: XOR, out: 8'hCC, c: 1'b0, e: 1'b0};
    v[4] = '{a: 8'hC0, b: 8'h50, cin: 1'b0, op: ADD, out: 8'h10, c: 1'b1, e: 1'b0};
    prev = {out, carry_out, err};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst = 1'b0; a = v[i].a; b = v[i].b; carry_in = v[i].cin; op = v[i].op;
      #1;
      tests_run++;
      if ({out, carry_out, err} !== prev) begin
        tests_failed++;
        $display("[TB] FAIL b2b_hold[%0d]: got %h, want %h", i, {out, carry_out, err}, prev);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if ({out, carry_out, err} !== {v[i].out, v[i].c, v[i].e}) begin
        tests_failed++;
        $display("[TB] FAIL b2b_result[%0d]: got out=%h c=%b e=%b, want out=%h c=%b e=%b",
                 i, out, carry_out, err, v[i].out, v[i].c, v[i].e);
      end
      prev = {out, carry_out, err};
    end
    apply_op(1'b1, '{a: 8'hFF, b: 8'hFF, cin: 1'b1, op: XOR, out: 8'h00, c: 1'b0, e: 1'b0});
    tests_run++;
    if ({out, carry_out, err} !== {8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_reset: got out=%h c=%b e=%b, want 00 0 0", out, carry_out, err);
    end
    apply_op(1'b0, '{a: 8'd3, b: 8'd4, cin: 1'b0, op: ADD, out: 8'd7, c: 1'b0, e: 1'b0});
    tests_run++;
    if ({out, carry_out, err} !== {8'd7, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_resume: got out=%h c=%b e=%b, want 07 0 0", out, carry_out, err);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b1;
    a        = '0;
    b        = '0;
    carry_in = 1'b0;
    op       = ADD;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
